// File: rtl/cpu_run_ctrl_pkg.sv
// Shared state encoding and widths for the core run controller.
package cpu_run_ctrl_pkg;

    localparam int STATE_W    = 3;
    localparam int STEP_CNT_W = 16;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 3'd0,
        RST_HOLD  = 3'd1,
        HALT      = 3'd2,
        RUN       = 3'd3,
        STEP      = 3'd4
    } run_state_t;

endpackage

// File: rtl/cpu_run_ctrl_key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, level debounce, 1-cycle press pulse on accepted 1->0.
// Latency: press appears 2 + DEBOUNCE cycles after a clean key fall.
// Backpressure: none; pulses are fire-and-forget.
module key_debounce #(
    parameter int DEBOUNCE = 250000
) (
    input  logic clock,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          key_s;

    assign key_s = sync_q[1];

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_n};
            press  <= 1'b0;
            // The count only runs while the new level persists; any return clears it.
            if (key_s == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= key_s;
                press   <= ~key_s;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Core bring-up and run/halt/step sequencer; optional breakpoint halt under CPU_RUN_CTRL_BREAKPOINT_EN.
// Latency: cpu_resetn/cpu_clk_en registered from next state (breakpoint gating is combinational).
// Backpressure: none; key presses arriving in states that do not use them are dropped.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int LOCK_STABLE = 1024,
    parameter int RESET_HOLD  = 16,
    parameter int DEBOUNCE    = 250000,
    parameter int START_RUN   = 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  key_run_n,
    input  logic                  key_step_n,
    input  logic [31:0]           pc,
    input  logic [31:0]           bp_addr,
    output logic                  cpu_resetn,
    output logic                  cpu_clk_en,
    output logic [STATE_W-1:0]    state,
    output logic [STEP_CNT_W-1:0] step_count
);

    localparam int TMAX = (LOCK_STABLE > RESET_HOLD) ? LOCK_STABLE : RESET_HOLD;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(RESET_HOLD - 1);

    run_state_t            state_q, state_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [1:0]            lock_sync_q;
    logic                  lock_s;
    logic                  run_press, step_press;
    logic                  resetn_q, clk_en_q;
    logic [STEP_CNT_W-1:0] step_count_q;
    logic                  bp_hit;

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_run (
        .clock (clock),
        .rst   (rst),
        .key_n (key_run_n),
        .press (run_press)
    );

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_step (
        .clock (clock),
        .rst   (rst),
        .key_n (key_step_n),
        .press (step_press)
    );

    assign lock_s = lock_sync_q[1];

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    // Masks the compare for the first enabled cycle after HALT so the core
    // can execute the instruction it stopped on.
    logic bp_mask_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) bp_mask_q <= 1'b0;
        else     bp_mask_q <= (state_q == HALT);
    end

    assign bp_hit     = (state_q == RUN) && !bp_mask_q && (pc == bp_addr);
    assign cpu_clk_en = clk_en_q & ~bp_hit;
`else
    logic unused_bp;
    assign unused_bp  = ^{pc, bp_addr};
    assign bp_hit     = 1'b0;
    assign cpu_clk_en = clk_en_q;
`endif

    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    if (tmr_q == LOCK_LAST) state_d = RST_HOLD;
                    else                    tmr_d   = tmr_q + TW'(1);
                end
            end
            RST_HOLD: begin
                if (tmr_q == HOLD_LAST) state_d = (START_RUN != 0) ? RUN : HALT;
                else                    tmr_d   = tmr_q + TW'(1);
            end
            HALT: begin
                if (run_press)       state_d = RUN;
                else if (step_press) state_d = STEP;
            end
            RUN: begin
                if (run_press || bp_hit) state_d = HALT;
            end
            STEP:    state_d = HALT;
            default: state_d = WAIT_LOCK;
        endcase
        if (!lock_s && (state_q != WAIT_LOCK)) begin
            state_d = WAIT_LOCK;
            tmr_d   = '0;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            lock_sync_q  <= 2'b00;
            state_q      <= WAIT_LOCK;
            tmr_q        <= '0;
            resetn_q     <= 1'b0;
            clk_en_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[0], pll_locked};
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            resetn_q    <= (state_d != WAIT_LOCK) && (state_d != RST_HOLD);
            clk_en_q    <= (state_d == RUN) || (state_d == STEP);
            if ((state_q == WAIT_LOCK) || (state_q == RST_HOLD))
                step_count_q <= '0;
            else if (cpu_clk_en)
                step_count_q <= step_count_q + STEP_CNT_W'(1);
        end
    end

    assign cpu_resetn = resetn_q;
    assign state      = state_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus queues expected snapshots, a monitor compares on
// every state change and on explicit probe requests.
module tb_cpu_run_ctrl;

    localparam int S_WL = 0, S_RH = 1, S_HALT = 2, S_RUN = 3, S_STEP = 4;

    logic        clock, rst, pll_locked, key_run_n, key_step_n;
    logic [31:0] pc, bp_addr;
    logic        cpu_resetn, cpu_clk_en;
    logic [2:0]  state;
    logic [15:0] step_count;

    typedef struct {
        string name;
        int    st;
        int    rn;
        int    ce;
        int    sc;   // -1: not checked
        int    dt;   // cycles since previous compare, -1: not checked
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   probe_cnt = 0;

    cpu_run_ctrl #(
        .LOCK_STABLE (8),
        .RESET_HOLD  (4),
        .DEBOUNCE    (4),
        .START_RUN   (1)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .pll_locked (pll_locked),
        .key_run_n  (key_run_n),
        .key_step_n (key_step_n),
        .pc         (pc),
        .bp_addr    (bp_addr),
        .cpu_resetn (cpu_resetn),
        .cpu_clk_en (cpu_clk_en),
        .state      (state),
        .step_count (step_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Core model: pc advances by one instruction on each enabled clock.
    always @(posedge clock or posedge rst) begin
        if (rst || !cpu_resetn) pc <= 32'd0;
        else if (cpu_clk_en)    pc <= pc + 32'd4;
    end

    task automatic expect_ev(input string name, input int st, input int rn, input int ce,
                             input int sc, input int dt);
        exp_t e;
        e.name = name; e.st = st; e.rn = rn; e.ce = ce; e.sc = sc; e.dt = dt;
        sb.push_back(e);
    endtask

    task automatic probe(input string name, input int st, input int rn, input int ce,
                         input int sc, input int dt);
        expect_ev(name, st, rn, ce, sc, dt);
        probe_cnt++;
    endtask

    task automatic compare_now(input int cyc);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: state=%0d resetn=%0b clk_en=%0b step_count=%0d after %0d cycles, none expected",
                     state, cpu_resetn, cpu_clk_en, step_count, cyc);
            return;
        end
        e = sb.pop_front();
        if (int'(state) != e.st || int'(cpu_resetn) != e.rn || int'(cpu_clk_en) != e.ce ||
            (e.sc >= 0 && int'(step_count) != e.sc) || (e.dt >= 0 && cyc != e.dt)) begin
            errors++;
            $display("FAIL %s: got state=%0d resetn=%0b clk_en=%0b step_count=%0d dt=%0d, want state=%0d resetn=%0d clk_en=%0d step_count=%0d dt=%0d",
                     e.name, state, cpu_resetn, cpu_clk_en, step_count, cyc,
                     e.st, e.rn, e.ce, e.sc, e.dt);
        end
    endtask

    initial begin : monitor
        int         cyc;
        int         seen;
        logic [2:0] prev;
        cyc  = 0;
        seen = 0;
        prev = 3'd0;
        forever begin
            @(negedge clock or probe_cnt);
            if (probe_cnt != seen) begin
                seen = probe_cnt;
                compare_now(cyc);
                cyc  = 0;
                prev = state;
            end else begin
                cyc++;
                if (state !== prev) begin
                    compare_now(cyc);
                    cyc  = 0;
                    prev = state;
                end
            end
        end
    end

    initial begin : stimulus
        rst        = 1'b1;
        pll_locked = 1'b0;
        key_run_n  = 1'b1;
        key_step_n = 1'b1;
        bp_addr    = 32'hFFFF_FFF0;
        repeat (3) @(negedge clock);
        #1 probe("reset", S_WL, 0, 0, 0, -1);
        @(negedge clock);
        rst = 1'b0;
        repeat (2) @(negedge clock);

        // Bring-up: 2 sync + 8 stable + 4 hold cycles.
        pll_locked = 1'b1;
        #1 probe("lock_rise", S_WL, 0, 0, 0, -1);
        expect_ev("enter_rst_hold", S_RH, 0, 0, 0, 10);
        expect_ev("enter_run", S_RUN, 1, 1, 0, 4);
        repeat (20) @(negedge clock);

        // Run key held 10 cycles: one halt.
        key_run_n = 1'b0;
        #1 probe("run_before_press", S_RUN, 1, 1, 6, 6);
        expect_ev("run_to_halt", S_HALT, 1, 0, 13, 7);
        repeat (10) @(negedge clock);
        key_run_n = 1'b1;
        repeat (10) @(negedge clock);

        // 2-cycle bounce must be filtered.
        key_run_n = 1'b0;
        #1 probe("halt_frozen", S_HALT, 1, 0, 13, 13);
        repeat (2) @(negedge clock);
        key_run_n = 1'b1;
        repeat (8) @(negedge clock);
        #1 probe("bounce_ignored", S_HALT, 1, 0, 13, 10);

        // Three single steps.
        for (int i = 0; i < 3; i++) begin
            key_step_n = 1'b0;
            expect_ev("step_enter", S_STEP, 1, 1, 13 + i, (i == 0) ? 7 : 13);
            expect_ev("step_exit", S_HALT, 1, 0, 14 + i, 1);
            repeat (6) @(negedge clock);
            key_step_n = 1'b1;
            repeat (8) @(negedge clock);
        end

        key_run_n = 1'b0;
        #1 probe("after_steps", S_HALT, 1, 0, 16, 6);
        expect_ev("resume_run", S_RUN, 1, 1, 16, 7);
        repeat (6) @(negedge clock);
        key_run_n = 1'b1;
        repeat (12) @(negedge clock);

        // Lock loss during RUN.
        pll_locked = 1'b0;
        #1 probe("run_before_lock_loss", S_RUN, 1, 1, 27, 11);
        expect_ev("lock_loss", S_WL, 0, 0, -1, 3);
        repeat (10) @(negedge clock);

        // Relock with a 1-cycle glitch: release delayed by 4 cycles.
        pll_locked = 1'b1;
        #1 probe("relock_wait", S_WL, 0, 0, 0, 7);
        expect_ev("glitch_rst_hold", S_RH, 0, 0, 0, 14);
        expect_ev("glitch_run", S_RUN, 1, 1, 0, 4);
        repeat (3) @(negedge clock);
        pll_locked = 1'b0;
        @(negedge clock);
        pll_locked = 1'b1;
        repeat (14) @(negedge clock);
        repeat (12) @(negedge clock);

        // Asynchronous reset between clock edges.
        @(posedge clock);
        #3 rst = 1'b1;
        #1 probe("async_rst", S_WL, 0, 0, 0, -1);
        @(negedge clock);
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        bp_addr = 32'h0000_0010;
`endif
        rst = 1'b0;
        #1 probe("rst_release", S_WL, 0, 0, 0, -1);
        expect_ev("rerun_rst_hold", S_RH, 0, 0, 0, 10);
        expect_ev("rerun_run", S_RUN, 1, 1, 0, 4);
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        repeat (17) @(negedge clock);
        @(posedge clock);
        #2 probe("bp_gate", S_RUN, 1, 0, 4, 3);
        expect_ev("bp_halt", S_HALT, 1, 0, 4, 2);
        repeat (3) @(negedge clock);
        key_step_n = 1'b0;
        expect_ev("bp_step", S_STEP, 1, 1, 4, 8);
        expect_ev("bp_step_exit", S_HALT, 1, 0, 5, 1);
        repeat (6) @(negedge clock);
        key_step_n = 1'b1;
        repeat (8) @(negedge clock);
`else
        repeat (20) @(negedge clock);
`endif

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_events: %0d expected events never seen (first: %s), want 0",
                     sb.size(), sb[0].name);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
